// File: rtl/aes_enc_pipe.sv
// Fully pipelined AES-128 encryptor: a sequential key-schedule FSM fills rk0..rk10,
// then eleven registered round stages accept one block per clock.
package aes_enc_pkg;
    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction
endpackage

// Combinational AES S-box: GF(2^8) inverse as a^254, then the affine map.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    import aes_enc_pkg::*;

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (z[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    logic [7:0] sq, inv;

    always_comb begin
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
    end

    assign y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

// One registered AES round; LAST drops MixColumns for the final round.
module aes_round #(
    parameter bit LAST = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] d,
    input  logic [127:0] rk,
    output logic [127:0] q
);
    import aes_enc_pkg::*;

    logic [0:15][7:0] din, sub, sr, mix;

    assign din = d;

    for (genvar b = 0; b < 16; b++) begin : g_byte
        aes_sbox u_sbox (.a(din[b]), .y(sub[b]));
        // byte (row r, col c) takes the S-box output from column (c + r) mod 4
        assign sr[b] = sub[(b % 4) + 4 * (((b / 4) + (b % 4)) % 4)];
    end

    if (LAST) begin : g_last
        assign mix = sr;
    end else begin : g_mix
        for (genvar c = 0; c < 4; c++) begin : g_col
            logic [7:0] a0, a1, a2, a3;
            assign a0 = sr[4*c];
            assign a1 = sr[4*c+1];
            assign a2 = sr[4*c+2];
            assign a3 = sr[4*c+3];
            assign mix[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            assign mix[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            assign mix[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            assign mix[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) q <= '0;
        else      q <= mix ^ rk;
    end
endmodule

module aes_enc_pipe #(
    parameter int BLOCK_LENGTH = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BLOCK_LENGTH-1:0] KEY,
    input  logic                    key_load,
    input  logic [BLOCK_LENGTH-1:0] IN,
    input  logic                    enable,
    output logic                    key_ready,
    output logic                    busy,
    output logic [BLOCK_LENGTH-1:0] OUT,
    output logic                    valid_out
);
    localparam int NR = 10;

    typedef enum logic [1:0] {IDLE, EXPAND, READY} kstate_t;

    kstate_t                         state, state_nxt;
    logic                            key_acc;
    logic [3:0]                      kcnt;
    logic [0:NR][BLOCK_LENGTH-1:0]   rk_q;
    logic [BLOCK_LENGTH-1:0]         prev, rk_nxt;
    logic [31:0]                     rot, subw, t, w0, w1, w2, w3;
    logic [7:0]                      rcon;
    logic [NR:0]                     en_pipe;
    logic [BLOCK_LENGTH-1:0]         s0;
    logic [BLOCK_LENGTH-1:0]         stg [NR+1];

    // ---- key schedule: one round key per cycle from the previous one
    always_comb begin
        prev = '0;
        for (int i = 0; i < NR; i++)
            if (kcnt == 4'(i + 1)) prev = rk_q[i];
        case (kcnt)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign rot = {prev[23:0], prev[31:24]};

    for (genvar j = 0; j < 4; j++) begin : g_ksb
        aes_sbox u_sbox (.a(rot[8*j +: 8]), .y(subw[8*j +: 8]));
    end

    always_comb begin
        t      = subw ^ {rcon, 24'h0};
        w0     = prev[127:96] ^ t;
        w1     = prev[95:64]  ^ w0;
        w2     = prev[63:32]  ^ w1;
        w3     = prev[31:0]   ^ w2;
        rk_nxt = {w0, w1, w2, w3};
    end

    // Loads are refused while blocks are in flight so their keys stay intact;
    // a block accepted on the load edge still sees old keys because each rk[r]
    // is rewritten on the same edge that stage r samples it.
    always_comb begin
        state_nxt = state;
        key_acc   = 1'b0;
        case (state)
            IDLE, READY: begin
                if (key_load && !busy) begin
                    key_acc   = 1'b1;
                    state_nxt = EXPAND;
                end
            end
            EXPAND: begin
                if (key_load)               key_acc   = 1'b1;
                else if (kcnt == 4'(NR))    state_nxt = READY;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rk_q <= '0;
            kcnt <= '0;
        end else if (key_acc) begin
            rk_q[0] <= KEY;
            kcnt    <= 4'd1;
        end else if (state == EXPAND) begin
            for (int i = 1; i <= NR; i++)
                if (kcnt == 4'(i)) rk_q[i] <= rk_nxt;
            kcnt <= (kcnt == 4'(NR)) ? 4'd0 : kcnt + 4'd1;
        end
    end

    assign key_ready = (state == READY);

    // ---- data pipe; stage data is free-running, en_pipe qualifies it
    always_ff @(posedge clk) begin
        if (!rst) begin
            en_pipe <= '0;
            s0      <= '0;
        end else begin
            en_pipe <= {en_pipe[NR-1:0], enable & key_ready};
            s0      <= IN ^ rk_q[0];
        end
    end

    assign stg[0] = s0;

    for (genvar r = 1; r <= NR; r++) begin : g_rnd
        aes_round #(.LAST(r == NR)) u_round (
            .clk (clk),
            .rst (rst),
            .d   (stg[r-1]),
            .rk  (rk_q[r]),
            .q   (stg[r])
        );
    end

    assign valid_out = en_pipe[NR];
    assign busy      = |en_pipe;
    assign OUT       = valid_out ? stg[NR] : '0;
endmodule

// File: tb/tb_aes_enc_pipe.sv
// Randomized bench for aes_enc_pipe: cycle-level scoreboard around a byte-array
// AES-128 reference, plus FIPS-197 known-answer checks.
module tb_aes_enc_pipe;
    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         key_load = 1'b0;
    logic         enable = 1'b0;
    logic [127:0] KEY = '0;
    logic [127:0] IN = '0;
    logic         key_ready, busy, valid_out;
    logic [127:0] OUT;

    aes_enc_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .KEY       (KEY),
        .key_load  (key_load),
        .IN        (IN),
        .enable    (enable),
        .key_ready (key_ready),
        .busy      (busy),
        .OUT       (OUT),
        .valid_out (valid_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---- reference AES built from log/antilog tables
    logic [7:0] sb [256];

    function automatic logic [7:0] mul2(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    task automatic build_sbox();
        logic [7:0] ex [256];
        int         lg [256];
        logic [7:0] p, inv;
        p = 8'h01;
        for (int i = 0; i < 255; i++) begin
            ex[i] = p;
            lg[p] = i;
            p = p ^ mul2(p);
        end
        for (int a = 0; a < 256; a++) begin
            inv = (a == 0) ? 8'h00 : ex[(255 - lg[a]) % 255];
            sb[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   st [16];
        logic [7:0]   tmp [16];
        logic [7:0]   a [4];
        logic [7:0]   rc;
        logic [31:0]  t;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = mul2(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    tmp[r+4*c] = sb[st[r + 4*((c+r)%4)]];
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) a[r] = tmp[r+4*c];
                for (int r = 0; r < 4; r++)
                    st[r+4*c] = (rnd == 10) ? a[r] :
                        mul2(a[r]) ^ mul2(a[(r+1)%4]) ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
            end
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---- cycle-level model: edge n decides using pre-edge inputs
    int           cyc = 0;
    int           m_kr_edge = -1;
    int           last_acc = -100;
    bit           m_init = 1'b0;
    logic [127:0] m_key = '0;
    logic [127:0] exp_d [int];
    logic [127:0] got_q [$];
    int           en, mn;
    bit           kr_pre, bz_pre, ev;

    always @(posedge clk) begin
        en = cyc;
        if (!rst) begin
            m_kr_edge = -1;
            last_acc  = -100;
            exp_d.delete();
            m_init    = 1'b1;
        end else if (m_init) begin
            kr_pre = (m_kr_edge >= 0) && (en - 1 >= m_kr_edge);
            bz_pre = (last_acc >= en - 11);
            if (enable && kr_pre) begin
                exp_d[en + 10] = aes_ref(m_key, IN);
                last_acc = en;
            end
            if (key_load && !bz_pre) begin
                m_key     = KEY;
                m_kr_edge = en + 10;
            end
        end
        cyc = en + 1;
    end

    always @(negedge clk) begin
        if (m_init) begin
            mn = cyc - 1;
            ev = exp_d.exists(mn);
            chk("valid_out", {127'b0, valid_out}, {127'b0, ev});
            chk("OUT", OUT, ev ? exp_d[mn] : 128'h0);
            chk("key_ready", {127'b0, key_ready}, {127'b0, (m_kr_edge >= 0) && (mn >= m_kr_edge)});
            chk("busy", {127'b0, busy}, {127'b0, last_acc >= mn - 10});
            if (valid_out) got_q.push_back(OUT);
            if (ev) exp_d.delete(mn);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy; i++) step();
        if (busy) chk("idle_timeout", {127'b0, busy}, 128'h0);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 30 && !key_ready; i++) step();
        if (!key_ready) chk("ready_timeout", {127'b0, key_ready}, 128'h1);
    endtask

    task automatic kat(input string tag, input logic [127:0] exp);
        chk({tag, "_count"}, 128'(got_q.size()), 128'h1);
        if (got_q.size() > 0) chk(tag, got_q[0], exp);
    endtask

    initial begin
        build_sbox();

        // reset with garbage on every input
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            IN = rnd128(); KEY = rnd128();
            enable = 1'($urandom % 2); key_load = 1'($urandom % 2);
            step();
        end
        rst = 1'b1; enable = 1'b0; key_load = 1'b0;
        step();

        // FIPS-197 key expansion
        KEY = K1; key_load = 1'b1; step();
        key_load = 1'b0; KEY = rnd128();
        wait_ready();
        chk("rk10", dut.rk_q[10], RK10);

        // single block
        got_q.delete();
        IN = P1; enable = 1'b1; step();
        enable = 1'b0;
        wait_idle();
        kat("kat_single", C1);

        // 16-block stream with an ignored key_load mid-flight
        got_q.delete();
        for (int i = 0; i < 16; i++) begin
            IN = (i % 2) ? P2 : P1; enable = 1'b1;
            key_load = (i == 5); KEY = K2;
            step();
        end
        enable = 1'b0; key_load = 1'b0;
        wait_idle();
        chk("stream_count", 128'(got_q.size()), 128'd16);
        for (int i = 0; i < got_q.size(); i++)
            chk("stream", got_q[i], (i % 2) ? aes_ref(K1, P2) : C1);

        // reload while idle; enables during expansion must be dropped
        KEY = K2; key_load = 1'b1; step();
        key_load = 1'b0;
        for (int i = 0; i < 6; i++) begin
            IN = rnd128(); enable = 1'b1; step();
        end
        enable = 1'b0;
        wait_ready();
        got_q.delete();
        IN = P2; enable = 1'b1; step();
        enable = 1'b0;
        wait_idle();
        kat("kat_k2", C2);

        // simultaneous load and block: block uses old key K2
        got_q.delete();
        KEY = K1; key_load = 1'b1; IN = P2; enable = 1'b1; step();
        key_load = 1'b0; enable = 1'b0;
        wait_idle();
        kat("old_key", C2);
        wait_ready();
        got_q.delete();
        IN = P1; enable = 1'b1; step();
        enable = 1'b0;
        wait_idle();
        kat("new_key", C1);

        // random traffic with occasional key loads
        for (int i = 0; i < 300; i++) begin
            enable = 1'($urandom % 2);
            key_load = ($urandom % 40 == 0);
            KEY = rnd128(); IN = rnd128();
            step();
        end
        enable = 1'b0; key_load = 1'b0;
        wait_idle();
        wait_ready();

        // abort with five blocks in flight
        got_q.delete();
        for (int i = 0; i < 5; i++) begin
            IN = rnd128(); enable = 1'b1; step();
        end
        enable = 1'b0; rst = 1'b0; step();
        rst = 1'b1;
        chk("abort_busy", {127'b0, busy}, 128'h0);
        chk("abort_valid", {127'b0, valid_out}, 128'h0);
        for (int i = 0; i < 20; i++) begin
            IN = rnd128(); enable = 1'($urandom % 2); step();
        end
        enable = 1'b0;
        chk("abort_no_output", 128'(got_q.size()), 128'h0);
        chk("abort_key_ready", {127'b0, key_ready}, 128'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
